// File: rtl/seg_overlay_vga_if.sv
// -----------------------------------------------------------------------------
// seg_overlay_vga_if
//   Read bus between the display engine and the synchronous class-map memory.
//   The memory returns mem_rdata exactly one cycle after mem_rd_en.
//
//   mem_rd_en  master->slave  read strobe
//   mem_addr   master->slave  class-map word address
//   mem_rdata  slave->master  class index for the previous cycle's address
// -----------------------------------------------------------------------------
interface seg_overlay_vga_if #(
    parameter int ADDR_W  = 16,
    parameter int CLASS_W = 8
);
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [CLASS_W-1:0] mem_rdata;

    modport master (output mem_rd_en, output mem_addr, input  mem_rdata);
    modport slave  (input  mem_rd_en, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/seg_overlay_vga.sv
// -----------------------------------------------------------------------------
// seg_overlay_vga
//   VGA display engine for segmentation class maps. Walks the VGA raster,
//   fetches one class index per pixel from the frame memory (upscaled by an
//   integer SCALE with counters, no divider), maps it through a writable RGB
//   palette and drives pixel-aligned colour, sync and blank. Single-frame or
//   continuous operation with frame-done reporting.
//
// Ports
//   clk, rst               pixel clock, asynchronous active-high reset
//   start                  begin display (sampled in IDLE only)
//   continuous             repeat frames (sampled at each frame end)
//   stop                   halt at the next frame end (latched while ACTIVE)
//   mem_if                 class-map read bus (master side)
//   pal_we/waddr/wdata     palette write port, {R,G,B}
//   vga_r/g/b              colour, vga_hsync/vga_vsync active-low sync
//   vga_blank_n            high in the visible area
//   busy                   high while ACTIVE
//   frame_done             one-cycle pulse at each frame end
//   frame_count            completed frames (wraps)
//
// Pipeline: counters (h,v) -> S1 address/control regs -> S2 memory data
//           -> S3 palette lookup onto vga_*; all outputs are 3 cycles behind
//           the counters.
// -----------------------------------------------------------------------------
module seg_overlay_vga #(
    parameter int          H_VIS       = 640,
    parameter int          H_FP        = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BP        = 48,
    parameter int          V_VIS       = 480,
    parameter int          V_FP        = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BP        = 33,
    parameter int          IMG_W       = 224,
    parameter int          IMG_H       = 224,
    parameter int          SCALE       = 2,
    parameter int          NUM_CLASSES = 21,
    parameter int          CLASS_W     = 8,
    parameter int          ADDR_W      = 16,
    parameter logic [23:0] BORDER_RGB  = 24'h000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               continuous,
    input  logic               stop,
    seg_overlay_vga_if.master  mem_if,
    input  logic               pal_we,
    input  logic [CLASS_W-1:0] pal_waddr,
    input  logic [23:0]        pal_wdata,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               vga_blank_n,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        frame_count
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    // Scaled image extent, clipped to the visible area.
    localparam int H_IMG_END = (IMG_W * SCALE < H_VIS) ? IMG_W * SCALE : H_VIS;
    localparam int V_IMG_END = (IMG_H * SCALE < V_VIS) ? IMG_H * SCALE : V_VIS;

    localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]     H_VIS_C  = HW'(H_VIS);
    localparam logic [HW-1:0]     H_IMG_C  = HW'(H_IMG_END);
    localparam logic [HW-1:0]     HS_BEG   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0]     HS_END   = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]     V_VIS_C  = VW'(V_VIS);
    localparam logic [VW-1:0]     V_IMG_C  = VW'(V_IMG_END);
    localparam logic [VW-1:0]     VS_BEG   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0]     VS_END   = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [1:0]        SUB_LAST = 2'(SCALE - 1);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    // Per-pixel control travelling alongside the memory access.
    typedef struct packed {
        logic vis;
        logic img;
        logic hs;
        logic vs;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{vis: 1'b0, img: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic logic [23:0] pal_default(input int idx);
        case (idx)
            0:       return 24'h000000;
            1:       return 24'hFF0000;
            2:       return 24'h00FF00;
            3:       return 24'h0000FF;
            default: return 24'h808080;
        endcase
    endfunction

    // Raster / control state
    state_t            state_q,      state_d;
    logic [HW-1:0]     h_q,          h_d;
    logic [VW-1:0]     v_q,          v_d;
    logic [1:0]        sub_x_q,      sub_x_d;
    logic [1:0]        sub_y_q,      sub_y_d;
    logic [ADDR_W-1:0] img_x_q,      img_x_d;
    logic [ADDR_W-1:0] line_base_q,  line_base_d;
    logic              stop_q,       stop_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_count_q, frame_count_d;

    // Pipeline
    ctrl_t             ctrl0;
    logic              rd_en_q,      rd_en_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    ctrl_t             c1_q,         c1_d;
    ctrl_t             c2_q,         c2_d;
    logic [23:0]       rgb_q,        rgb_d;
    logic              hs_q,         hs_d;
    logic              vs_q,         vs_d;
    logic              blank_n_q,    blank_n_d;

    // Palette register file
    logic [23:0]       pal_q [NUM_CLASSES];
    logic [23:0]       pal_d [NUM_CLASSES];

    // -------------------------------------------------------------------------
    // FSM, raster counters and divider-free address counters
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // block can leave a value unassigned and infer a latch.
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        sub_x_d       = sub_x_q;
        sub_y_d       = sub_y_q;
        img_x_d       = img_x_q;
        line_base_d   = line_base_q;
        stop_d        = stop_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;

        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (start) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (stop) stop_d = 1'b1;
                if (h_q == H_LAST && v_q == V_LAST) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    h_d           = '0;
                    v_d           = '0;
                    sub_x_d       = '0;
                    sub_y_d       = '0;
                    img_x_d       = '0;
                    line_base_d   = '0;
                    // A stop arriving on the final cycle counts as latched.
                    if (!continuous || stop_q || stop) begin
                        state_d = ST_IDLE;
                        stop_d  = 1'b0;
                    end
                end else if (h_q == H_LAST) begin
                    h_d     = '0;
                    v_d     = v_q + VW'(1);
                    sub_x_d = '0;
                    img_x_d = '0;
                    // Advance one class-map row every SCALE raster lines.
                    if (v_q < V_IMG_C) begin
                        if (sub_y_q == SUB_LAST) begin
                            sub_y_d     = '0;
                            line_base_d = line_base_q + IMG_W_A;
                        end else begin
                            sub_y_d = sub_y_q + 2'd1;
                        end
                    end
                end else begin
                    h_d = h_q + HW'(1);
                    // Advance one class-map column every SCALE pixels.
                    if (h_q < H_IMG_C) begin
                        if (sub_x_q == SUB_LAST) begin
                            sub_x_d = '0;
                            img_x_d = img_x_q + ADDR_W'(1);
                        end else begin
                            sub_x_d = sub_x_q + 2'd1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Pixel pipeline
    // -------------------------------------------------------------------------
    always_comb begin
        // Outside ACTIVE the stage-0 control is the idle pattern, so the three
        // stages drain to idle outputs on their own after the last frame.
        ctrl0 = CTRL_IDLE;
        if (state_q == ST_ACTIVE) begin
            ctrl0.vis = (h_q < H_VIS_C) && (v_q < V_VIS_C);
            ctrl0.img = ctrl0.vis && (h_q < H_IMG_C) && (v_q < V_IMG_C);
            ctrl0.hs  = !((h_q >= HS_BEG) && (h_q < HS_END));
            ctrl0.vs  = !((v_q >= VS_BEG) && (v_q < VS_END));
        end

        // S1: address holds its last value when no read is issued.
        rd_en_d = ctrl0.img;
        addr_d  = ctrl0.img ? (line_base_q + img_x_q) : addr_q;
        c1_d    = ctrl0;

        // S2: memory returns the class index; control just waits alongside.
        c2_d    = c1_q;

        // S3: colour selection against the palette as it stands this cycle,
        // so a same-cycle write to the looked-up entry yields the old colour.
        rgb_d = 24'h000000;
        if (c2_q.vis) begin
            if (!c2_q.img) begin
                rgb_d = BORDER_RGB;
            end else begin
                rgb_d = 24'hFF00FF;
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    if (mem_if.mem_rdata == CLASS_W'(i)) rgb_d = pal_q[i];
                end
            end
        end
        hs_d      = c2_q.hs;
        vs_d      = c2_q.vs;
        blank_n_d = c2_q.vis;
    end

    // Palette write port; indices at or above NUM_CLASSES match no entry.
    always_comb begin
        pal_d = pal_q;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (pal_we && pal_waddr == CLASS_W'(i)) pal_d[i] = pal_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            h_q           <= '0;
            v_q           <= '0;
            sub_x_q       <= '0;
            sub_y_q       <= '0;
            img_x_q       <= '0;
            line_base_q   <= '0;
            stop_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            rd_en_q       <= 1'b0;
            addr_q        <= '0;
            c1_q          <= CTRL_IDLE;
            c2_q          <= CTRL_IDLE;
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            // NOTE: the palette is a small register file with defined power-on
            // colours, so it is reset here; a RAM-based table could not be.
            for (int i = 0; i < NUM_CLASSES; i++) pal_q[i] <= pal_default(i);
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            sub_x_q       <= sub_x_d;
            sub_y_q       <= sub_y_d;
            img_x_q       <= img_x_d;
            line_base_q   <= line_base_d;
            stop_q        <= stop_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            rd_en_q       <= rd_en_d;
            addr_q        <= addr_d;
            c1_q          <= c1_d;
            c2_q          <= c2_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            pal_q         <= pal_d;
        end
    end

    assign mem_if.mem_rd_en = rd_en_q;
    assign mem_if.mem_addr  = addr_q;
    assign vga_r            = rgb_q[23:16];
    assign vga_g            = rgb_q[15:8];
    assign vga_b            = rgb_q[7:0];
    assign vga_hsync        = hs_q;
    assign vga_vsync        = vs_q;
    assign vga_blank_n      = blank_n_q;
    assign busy             = (state_q == ST_ACTIVE);
    assign frame_done       = frame_done_q;
    assign frame_count      = frame_count_q;

endmodule

// File: tb/tb_seg_overlay_vga.sv
// -----------------------------------------------------------------------------
// tb_seg_overlay_vga
//   Small raster (56x27 total, 12x8 image at SCALE 2) so whole frames run
//   quickly. A reference model derives each pixel's expected memory access and
//   colour from raster position with plain division; expectations are queued
//   with the cycle they are due and a monitor compares them as they come due.
// -----------------------------------------------------------------------------
module tb_seg_overlay_vga;

    localparam int HV = 40, HFP = 4, HS = 6, HBP = 6;
    localparam int VV = 20, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VT = VV + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int IW = 12, IH = 8, SC = 2, NC = 21, CW = 8, AW = 16;
    localparam logic [23:0] BORDER = 24'h203040;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, continuous = 1'b0, stop = 1'b0;
    logic          pal_we = 1'b0;
    logic [CW-1:0] pal_waddr = '0;
    logic [23:0]   pal_wdata = '0;
    logic [7:0]    vga_r, vga_g, vga_b;
    logic          vga_hsync, vga_vsync, vga_blank_n, busy, frame_done;
    logic [15:0]   frame_count;

    seg_overlay_vga_if #(.ADDR_W(AW), .CLASS_W(CW)) mif ();

    seg_overlay_vga #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .SCALE(SC), .NUM_CLASSES(NC),
        .CLASS_W(CW), .ADDR_W(AW), .BORDER_RGB(BORDER)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
        .mem_if(mif.master),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous class-map memory: data one cycle after the read strobe.
    logic [CW-1:0] mem [65536];
    always @(posedge clk) if (mif.mem_rd_en) mif.mem_rdata <= mem[mif.mem_addr];

    // ---------------- reference model state ----------------
    logic [23:0] pal_m [NC];
    logic [AW-1:0] last_addr = '0;
    int fc_m = 0;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;
    exp_t mq[$];
    exp_t vq[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic pal_reset();
        for (int i = 0; i < NC; i++)
            pal_m[i] = (i == 0) ? 24'h000000 : (i == 1) ? 24'hFF0000 :
                       (i == 2) ? 24'h00FF00 : (i == 3) ? 24'h0000FF : 24'h808080;
    endtask

    task automatic pal_write(input logic [CW-1:0] a, input logic [23:0] d);
        pal_we = 1'b1; pal_waddr = a; pal_wdata = d;
        for (int i = 0; i < NC; i++) if (int'(a) == i) pal_m[i] = d;
    endtask

    // Expected response for raster position (h,v) seen by the counters in
    // cycle base+k: memory access one cycle later, video three cycles later.
    task automatic push_pixel(input int base, input int k, input bit act, input int h, input int v);
        bit vis, img, hs, vs;
        logic [23:0] rgb;
        int cls;
        exp_t e;
        vis = act && h < HV && v < VV;
        img = vis && h < IW * SC && v < IH * SC;
        hs  = !(act && h >= HV + HFP && h < HV + HFP + HS);
        vs  = !(act && v >= VV + VFP && v < VV + VFP + VS);
        rgb = 24'h000000;
        if (img) last_addr = AW'((v / SC) * IW + h / SC);
        if (vis && !img) rgb = BORDER;
        if (img) begin
            cls = int'(mem[last_addr]);
            rgb = 24'hFF00FF;
            for (int i = 0; i < NC; i++) if (cls == i) rgb = pal_m[i];
        end
        e.due = base + k + 1; e.val = 32'({img, last_addr});
        mq.push_back(e);
        e.due = base + k + 3; e.val = 32'({vis, hs, vs, rgb});
        vq.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        while (mq.size() > 0 && mq[0].due <= cyc) begin
            e = mq.pop_front();
            if (e.due != cyc) begin
                miscompares++;
                $display("FAIL mem_late at cycle %0d: due %0d", cyc, e.due);
            end else begin
                check("mem_rd", 32'({mif.mem_rd_en, mif.mem_addr}), e.val);
            end
        end
        while (vq.size() > 0 && vq[0].due <= cyc) begin
            e = vq.pop_front();
            if (e.due != cyc) begin
                miscompares++;
                $display("FAIL video_late at cycle %0d: due %0d", cyc, e.due);
            end else begin
                check("video", 32'({vga_blank_n, vga_hsync, vga_vsync, vga_r, vga_g, vga_b}), e.val);
            end
        end
    end

    task automatic check_reset_values();
        check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        check("rst_sync", 32'({vga_hsync, vga_vsync, vga_blank_n}), 32'b110);
        check("rst_mem", 32'({mif.mem_rd_en, mif.mem_addr}), 32'h0);
        check("rst_busy", 32'({busy, frame_done}), 32'h0);
        check("rst_fcount", 32'(frame_count), 32'h0);
    endtask

    // Runs from a negedge: start is captured at the next posedge, so the
    // counters sit at (0,0) in cycle base.
    task automatic run(input int nf, input bit cont, input int stop_k, input int start_k,
                       input int rst_k, input bit do_pal);
        int base, total, kk;
        bit fd;
        total = nf * FRAME;
        start = 1'b1;
        continuous = cont;
        base = cyc + 1;
        @(negedge clk);
        for (int k = 0; k < total + 4; k++) begin
            start = 1'b0; stop = 1'b0; pal_we = 1'b0;
            if (k == rst_k) begin
                mq.delete(); vq.delete();
                rst = 1'b1;
                #1;
                check_reset_values();
                fc_m = 0; last_addr = '0; pal_reset();
                continuous = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            fd = (k > 0) && (k % FRAME == 0) && (k <= total);
            check("busy", 32'(busy), 32'(k < total));
            check("frame_done", 32'(frame_done), 32'(fd));
            if (fd) check("frame_count", 32'(frame_count), 32'(fc_m + k / FRAME));
            if (do_pal && k == 5 * HT + 50) pal_write(8'd2, 24'h123456);
            if (do_pal && k == 6 * HT + 50) pal_write(8'd30, 24'hABCDEF);
            kk = k % FRAME;
            push_pixel(base, k, k < total, kk % HT, kk / HT);
            if (k == stop_k) stop = 1'b1;
            if (k == start_k) start = 1'b1;
            @(negedge clk);
        end
        fc_m += nf;
        continuous = 1'b0;
        check("busy_after_run", 32'(busy), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        for (int i = 0; i < IW * IH; i++) mem[i] = CW'($urandom_range(0, 30));
        mem[0] = 8'd1;           // first pixel: palette entry 1 (FF0000)
        mem[5] = 8'd25;          // out-of-range class
        mem[7] = 8'd2;           // class 2 before the palette write
        mem[IW * 5 + 3] = 8'd2;  // class 2 after the palette write
        pal_reset();

        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'({busy, vga_blank_n}), 32'h0);

        // Single frame with mid-frame palette writes (valid and ignored index).
        run(1, 1'b0, -1, -1, -1, 1'b1);
        // Continuous, stop pulsed in frame 3, stray start in frame 1.
        run(3, 1'b1, 2 * FRAME + 700, FRAME / 2, -1, 1'b0);
        check("frame_count_cont", 32'(frame_count), 32'(fc_m));
        // Reset mid-frame at (30,10).
        run(1, 1'b0, -1, -1, 10 * HT + 30, 1'b0);
        repeat (5) @(negedge clk);
        check("post_rst_idle", 32'({busy, vga_blank_n, mif.mem_rd_en}), 32'h0);
        // Clean restart; palette must be back at its defaults.
        run(1, 1'b0, -1, -1, -1, 1'b0);
        check("frame_count_final", 32'(frame_count), 32'(fc_m));

        repeat (8) @(negedge clk);
        check("queue_drain", 32'(mq.size() + vq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_overlay_vga.md
# seg_overlay_vga

Parametrised VGA display engine for segmentation class maps. It reads per-pixel class indices from a synchronous frame memory and upscales them by an integer factor. Each index is mapped through a runtime-writable RGB palette, and the engine produces aligned VGA colour, sync and blank signals. It sits after the segmentation output buffer and drives the board DAC. It supports single-frame and continuous modes, with frame-done reporting.

## Interface
- H_VIS, 640, visible pixels per line; H_FP 16, H_SYNC 96, H_BP 48: horizontal porch/sync lengths
- V_VIS, 480, visible lines; V_FP 10, V_SYNC 2, V_BP 33: vertical porch/sync lengths
- IMG_W, 224, class-map width; IMG_H, 224, class-map height
- SCALE, 2, integer upscale factor, legal 1..4
- NUM_CLASSES, 21, number of valid palette entries
- CLASS_W, 8, class index width; ADDR_W, 16, memory address width (≥ clog2(IMG_W*IMG_H))
- BORDER_RGB, 24'h000000, colour outside the scaled image

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin display; sampled in IDLE only
- continuous  in  1  1 = repeat frames until stop; sampled at each frame end
- stop  in  1  request halt at the next frame end (continuous mode)
- mem_rd_en  out  1  class-map read strobe
- mem_addr  out  ADDR_W  class-map address
- mem_rdata  in  CLASS_W  class index; valid exactly 1 cycle after mem_rd_en
- pal_we  in  1  palette write enable
- pal_waddr  in  CLASS_W  palette entry index (ignored if ≥ NUM_CLASSES)
- pal_wdata  in  24  {R,G,B}
- vga_r, vga_g, vga_b  out  8 each  colour
- vga_hsync, vga_vsync  out  1 each  active-low sync
- vga_blank_n  out  1  high during visible area
- busy  out  1  high in ACTIVE
- frame_done  out  1  one-cycle pulse at each frame end
- frame_count  out  16  completed frames, wraps at 65535 → 0

## Operation
- FSM: IDLE → ACTIVE on start. In ACTIVE at h=H_TOTAL-1, v=V_TOTAL-1:
  - frame_done pulses and frame_count increments.
  - If continuous=1 and stop is not latched, counters wrap to (0,0) and the FSM stays in ACTIVE.
  - Otherwise the FSM returns to IDLE.
- stop is latched while in ACTIVE and cleared on the return to IDLE. start while ACTIVE is ignored.
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way from the vertical parameters.
- Counters h, v run only in ACTIVE and are held at 0 in IDLE.
- hsync is low for H_VIS+H_FP ≤ h < H_VIS+H_FP+H_SYNC. vsync uses the same rule with the vertical parameters. blank_n = (h<H_VIS)&&(v<V_VIS).
- In-image region: h < IMG_W*SCALE and v < IMG_H*SCALE, also clipped to the visible area.
- Address generation uses no divider:
  - A sub-pixel counter advances img_x every SCALE pixels.
  - A sub-line counter adds IMG_W to line_base every SCALE lines.
  - mem_addr = line_base + img_x.
- mem_rd_en is asserted only for in-image pixels. mem_addr holds its last value otherwise.
- Colour selection, in priority order:
  - Not visible → 0.
  - Visible but outside the image → BORDER_RGB.
  - Class index ≥ NUM_CLASSES → 24'hFF00FF.
  - Otherwise → palette[index].
- Palette: NUM_CLASSES×24 registers. Reset values are entry 0 = 000000, 1 = FF0000, 2 = 00FF00, 3 = 0000FF, all others 808080.
- Palette writes are accepted in any state and are visible from the next cycle. A same-cycle write and lookup of the same entry returns the old value.

## Timing
- Pipeline latency is 3 cycles from counter (h,v) to output:
  - S1: mem_addr/mem_rd_en and the delayed control are registered.
  - S2: mem_rdata is returned.
  - S3: the palette lookup is registered onto vga_*.
- hsync, vsync and blank_n pass through matching 3-stage delays, so every output is pixel-aligned.
- On leaving ACTIVE, the pipeline flushes its remaining 3 stages. After that, outputs hold their idle values.
- Idle values are hsync=1, vsync=1, blank_n=0, rgb=0, mem_rd_en=0.
- Reset values: vga_r/g/b=0, hsync=1, vsync=1, blank_n=0, mem_rd_en=0, mem_addr=0, busy=0, frame_done=0, frame_count=0, FSM=IDLE, palette = defaults above.
- Reset mid-frame forces reset values immediately, with no flush. After reset is released, a new start is required.
- busy rises the cycle after start is sampled in IDLE. It falls the cycle after the frame_done that ends the run.

## Test plan
- Defaults with single frame and mem[0]=1: start → first rgb FF0000 with blank_n=1 at 3 cycles after h=0. The hsync low window spans exactly 96 cycles, from count 656+3 to 751+3. frame_done occurs once after 800*525 cycles, then busy=0.
- SCALE=2 address pattern: mem_addr = 0,0,1,1,… on line 0; line 1 repeats line 0; line 2 starts at 224. At h=448, mem_rd_en=0 and 3 cycles later rgb=BORDER_RGB. No reads occur for v ≥ 448.
- Class index 25 loaded → FF00FF. pal_we writes entry 2=123456 mid-frame → the following class-2 pixels show 123456. A write to index 30 changes nothing.
- continuous=1 for 3 frames, then stop pulsed mid-frame 3 → exactly 3 frame_done pulses, then frame_count=3 and busy=0. A start asserted mid-frame is ignored.
- rst asserted at h=300, v=100 → all outputs take reset values in the same cycle and the palette returns to its defaults. A subsequent start restarts cleanly from (0,0).
- SCALE=1, IMG 640×480 → mem_addr increments by 1 every visible pixel. The last address is 307199 with ADDR_W=19.
